jtpang_objdma: RTL and testbench

- Object DMA controller for the Pang/Mitchell video path.
- On a CPU DMA request, it takes the main CPU bus using the Z80 BUSRQ/BUSAK handshake.
- It then copies the object attribute table from shared attribute RAM into the object line-engine buffer and releases the bus.
- Sits between the main CPU bus signals (dma_go, busrq, busak_n) and the object buffer inside the video block.
- Double-buffers the object table so the renderer always reads a complete frame.

---
 rtl/jtpang_pkg.sv | 19 +
 rtl/jtpang_objdma.sv | 117 +++++++++++
 tb/tb_jtpang_objdma.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtpang_pkg.sv
// Shared constants for the Pang/Mitchell object DMA: FSM encoding and
// the default object-table size with its derived counter width.
package jtpang_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_COPY = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  localparam int OBJ_BYTES_DEF = 512;

  // One extra bit so the counter can run past the last byte for the drain ticks
  function automatic int cnt_width(input int bytes);
    return $clog2(bytes) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(OBJ_BYTES_DEF);

endpackage

// File: rtl/jtpang_objdma.sv
// Object DMA: grabs the Z80 bus via BUSRQ/BUSAK, copies the object table
// into the non-displayed buffer bank, then flips the bank the renderer reads.
module jtpang_objdma
  import jtpang_pkg::*;
#(
  parameter int             AW        = 12,
  parameter int             OBJ_BYTES = OBJ_BYTES_DEF,
  parameter logic [AW-1:0]  SRC_BASE  = {AW{1'b0}},
  parameter bit             VB_ONLY   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cen,
  input  logic                          LVBL,
  input  logic                          dma_go,
  output logic                          busrq,
  input  logic                          busak_n,
  output logic [AW-1:0]                 src_addr,
  output logic                          src_rd,
  input  logic [7:0]                    src_dout,
  output logic [cnt_width(OBJ_BYTES)-1:0] buf_addr,
  output logic [7:0]                    buf_din,
  output logic                          buf_we,
  output logic                          rd_bank,
  output logic                          busy
);

  localparam int CW = cnt_width(OBJ_BYTES);

  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic          pending_r;
  logic          start_s;

  assign start_s = cen && (state_r == ST_IDLE) && pending_r && (!VB_ONLY || !LVBL);

  // Request latch: dma_go can land between cen ticks, and a pulse coinciding
  // with the start decision must survive to launch one more transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= dma_go | (pending_r & ~start_s);
    end
  end

  // Bus handshake, copy pipeline and bank flip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      busrq    <= 1'b0;
      busy     <= 1'b0;
      src_rd   <= 1'b0;
      src_addr <= SRC_BASE;
      buf_we   <= 1'b0;
      buf_addr <= {CW{1'b0}};
      buf_din  <= 8'h00;
      rd_bank  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else if (cen) begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            busy    <= 1'b1;
            busrq   <= 1'b1;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!busak_n) begin
            src_addr <= SRC_BASE;
            src_rd   <= 1'b1;
            cnt_r    <= {CW{1'b0}};
            state_r  <= ST_COPY;
          end
        end
        ST_COPY: begin
          if (cnt_r == CW'(OBJ_BYTES + 1)) begin
            busrq   <= 1'b0;
            rd_bank <= ~rd_bank;
            state_r <= ST_REL;
          end else if (busak_n) begin
            // CPU took the bus back early: keep showing the old table
            busrq   <= 1'b0;
            src_rd  <= 1'b0;
            buf_we  <= 1'b0;
            state_r <= ST_REL;
          end else begin
            // Data for address cnt_r arrives now; the next address goes out
            cnt_r    <= cnt_r + CW'(1);
            buf_we   <= (cnt_r < CW'(OBJ_BYTES));
            buf_din  <= src_dout;
            buf_addr <= {~rd_bank, cnt_r[CW-2:0]};
            src_rd   <= (cnt_r < CW'(OBJ_BYTES - 1));
            if (cnt_r < CW'(OBJ_BYTES - 1)) begin
              src_addr <= SRC_BASE + AW'(cnt_r + CW'(1));
            end
          end
        end
        ST_REL: begin
          if (busak_n) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busrq   <= 1'b0;
          src_rd  <= 1'b0;
          buf_we  <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Scoreboard bench for jtpang_objdma: expected buffer writes are queued by
// the stimulus and popped by a monitor whenever the DUT writes.
module tb_jtpang_objdma;

  logic        clk, rst_n, cen, LVBL;
  logic        dma_go, busrq, busak_n, src_rd, buf_we, rd_bank, busy;
  logic [11:0] src_addr;
  logic [7:0]  src_dout, buf_din;
  logic [9:0]  buf_addr;
  logic        dma_go2, busrq2, busak2_n, src_rd2, buf_we2, rd_bank2, busy2;
  logic [11:0] src_addr2;
  logic [7:0]  src_dout2, buf_din2;
  logic [9:0]  buf_addr2;

  int checks = 0;
  int errors = 0;
  logic [17:0] q1[$];
  logic [17:0] q2[$];

  function automatic logic [7:0] pat1(input logic [11:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] pat2(input logic [11:0] a);
    return a[11:4] ^ {4'h0, a[3:0]};
  endfunction

  assign src_dout  = pat1(src_addr);
  assign src_dout2 = pat2(src_addr2);

  jtpang_objdma dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL), .dma_go(dma_go),
    .busrq(busrq), .busak_n(busak_n), .src_addr(src_addr), .src_rd(src_rd),
    .src_dout(src_dout), .buf_addr(buf_addr), .buf_din(buf_din),
    .buf_we(buf_we), .rd_bank(rd_bank), .busy(busy)
  );

  jtpang_objdma #(.AW(12), .OBJ_BYTES(512), .SRC_BASE(12'hF00), .VB_ONLY(1'b1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL), .dma_go(dma_go2),
    .busrq(busrq2), .busak_n(busak2_n), .src_addr(src_addr2), .src_rd(src_rd2),
    .src_dout(src_dout2), .buf_addr(buf_addr2), .buf_din(buf_din2),
    .buf_we(buf_we2), .rd_bank(rd_bank2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int cyc;
    cyc = 0;
    cen = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      cen = (cyc % 4 == 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // Write monitor: the buffer RAM commits on the next edge when cen && buf_we
  always @(negedge clk) begin
    logic [17:0] e;
    #1;
    if (cen && buf_we) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL wr_extra got %h exp none", {buf_addr, buf_din});
      end else begin
        e = q1.pop_front();
        if ({buf_addr, buf_din} !== e) begin
          errors++;
          $display("FAIL wr got %h exp %h", {buf_addr, buf_din}, e);
        end
      end
    end
    if (cen && buf_we2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL wr2_extra got %h exp none", {buf_addr2, buf_din2});
      end else begin
        e = q2.pop_front();
        if ({buf_addr2, buf_din2} !== e) begin
          errors++;
          $display("FAIL wr2 got %h exp %h", {buf_addr2, buf_din2}, e);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cen_step();
    while (!cen) tick();
    tick();
  endtask

  task automatic pulse_go(input bit sel);
    if (sel) dma_go2 = 1'b1; else dma_go = 1'b1;
    tick();
    dma_go  = 1'b0;
    dma_go2 = 1'b0;
  endtask

  task automatic push_exp(input bit sel, input bit bank, input int cnt, input logic [11:0] base);
    logic [11:0] a;
    for (int t = 0; t < cnt; t++) begin
      a = base + t[11:0];
      if (sel) q2.push_back({bank, t[8:0], pat2(a)});
      else     q1.push_back({bank, t[8:0], pat1(a)});
    end
  endtask

  // act: 0 plain, 1 extra go pulses, 2 early release, 3 reset, 4 LVBL rise
  task automatic xfer(input bit sel, input int ack_dly, input int act, input int at, output int n);
    int w;
    w = 0;
    while (!(sel ? busrq2 : busrq) && w < 64) begin cen_step(); w++; end
    check("busrq_req", 32'(sel ? busrq2 : busrq), 32'd1);
    repeat (ack_dly) cen_step();
    while (!cen) tick();
    if (sel) busak2_n = 1'b0; else busak_n = 1'b0;
    cen_step();
    n = 0;
    while ((sel ? busrq2 : busrq) && n < 600) begin
      if (act == 1 && (n == 10 || n == 11 || n == 300)) pulse_go(1'b0);
      if (act == 2 && n == at) busak_n = 1'b1;
      if (act == 4 && n == at) LVBL = 1'b1;
      if (act == 3 && n == at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busrq", 32'(busrq), 32'd0);
        check("rst_buf_we", 32'(buf_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_bank", 32'(rd_bank), 32'd0);
        break;
      end
      cen_step();
      n++;
    end
  endtask

  task automatic release_bus(input bit sel);
    int w;
    if (sel) busak2_n = 1'b1; else busak_n = 1'b1;
    w = 0;
    while ((sel ? busy2 : busy) && w < 16) begin cen_step(); w++; end
    check("busy_clear", 32'(sel ? busy2 : busy), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; LVBL = 1'b0;
    dma_go = 1'b0; busak_n = 1'b1; dma_go2 = 1'b0; busak2_n = 1'b1;
    repeat (3) tick();
    check("reset_busrq", 32'(busrq), 32'd0);
    check("reset_src_rd", 32'(src_rd), 32'd0);
    check("reset_buf_we", 32'(buf_we), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rd_bank", 32'(rd_bank), 32'd0);
    check("reset_src_addr", 32'(src_addr), 32'h000);
    check("reset_buf_addr", 32'(buf_addr), 32'h000);
    check("reset_src_addr2", 32'(src_addr2), 32'hF00);
    rst_n = 1'b1;
    tick();

    // Basic copy into bank 1
    push_exp(1'b0, 1'b1, 512, 12'h000);
    pulse_go(1'b0);
    cen_step();
    check("busy_start", 32'(busy), 32'd1);
    xfer(1'b0, 3, 0, 0, n);
    check("basic_latency", 32'(n), 32'd514);
    check("basic_rd_bank", 32'(rd_bank), 32'd1);
    release_bus(1'b0);

    // VB gating, then LVBL rising mid-copy must not stop it
    LVBL = 1'b1;
    push_exp(1'b0, 1'b0, 512, 12'h000);
    pulse_go(1'b0);
    for (int i = 0; i < 12; i++) begin
      cen_step();
      check("vb_hold", 32'(busrq), 32'd0);
    end
    while (!cen) tick();
    LVBL = 1'b0;
    cen_step();
    check("vb_start", 32'(busrq), 32'd1);
    xfer(1'b0, 2, 4, 50, n);
    LVBL = 1'b0;
    check("vb_latency", 32'(n), 32'd514);
    check("vb_rd_bank", 32'(rd_bank), 32'd0);
    release_bus(1'b0);

    // Three go pulses during COPY collapse into one follow-up transfer
    push_exp(1'b0, 1'b1, 512, 12'h000);
    push_exp(1'b0, 1'b0, 512, 12'h000);
    pulse_go(1'b0);
    xfer(1'b0, 1, 1, 0, n);
    check("b2b_first_rd_bank", 32'(rd_bank), 32'd1);
    release_bus(1'b0);
    xfer(1'b0, 0, 0, 0, n);
    check("b2b_latency", 32'(n), 32'd514);
    check("b2b_rd_bank", 32'(rd_bank), 32'd0);
    release_bus(1'b0);
    repeat (10) cen_step();
    check("b2b_no_third", 32'(busrq), 32'd0);

    // Early bus release at byte 100
    push_exp(1'b0, 1'b1, 100, 12'h000);
    pulse_go(1'b0);
    xfer(1'b0, 3, 2, 100, n);
    check("early_busrq", 32'(busrq), 32'd0);
    check("early_rd_bank", 32'(rd_bank), 32'd0);
    check("early_busy_held", 32'(busy), 32'd1);
    release_bus(1'b0);
    check("early_queue", 32'(q1.size()), 32'd0);

    // Full copy to show bank 1, then reset in the middle of the next copy
    push_exp(1'b0, 1'b1, 512, 12'h000);
    pulse_go(1'b0);
    xfer(1'b0, 0, 0, 0, n);
    check("pre_rst_rd_bank", 32'(rd_bank), 32'd1);
    release_bus(1'b0);
    push_exp(1'b0, 1'b0, 199, 12'h000);
    pulse_go(1'b0);
    xfer(1'b0, 3, 3, 200, n);
    busak_n = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (8) cen_step();
    check("rst_idle_busrq", 32'(busrq), 32'd0);
    check("rst_queue", 32'(q1.size()), 32'd0);

    // Source address wrap: F00..FFF then 000..0FF
    push_exp(1'b1, 1'b1, 512, 12'hF00);
    pulse_go(1'b1);
    xfer(1'b1, 3, 0, 0, n);
    check("wrap_latency", 32'(n), 32'd514);
    check("wrap_rd_bank", 32'(rd_bank2), 32'd1);
    release_bus(1'b1);
    repeat (4) cen_step();
    check("wrap_queue", 32'(q2.size()), 32'd0);
    check("main_queue", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
